// File: rtl/lcd_dispatch_pkg.sv
// rtl/lcd_dispatch_pkg.sv - shared state encodings and default counts for the LCD refresh dispatcher
package lcd_dispatch_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    localparam int DEF_HOLDOFF_COUNT = 25_000_000;
    localparam int DEF_TIMEOUT_COUNT = 50_000_000;

endpackage

// File: rtl/dispatch_timer.sv
// rtl/dispatch_timer.sv - cycle counter with clear/enable that pulses tc on its terminal count
module dispatch_timer #(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = $clog2(COUNT > 2 ? COUNT : 2);
    localparam logic [W-1:0] TC_VAL = W'(COUNT > 0 ? COUNT - 1 : 0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = enable && (cnt_q == TC_VAL);

    // Returning to zero on tc keeps the count from ever running past its terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tc) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_refresh_dispatcher.sv
// rtl/lcd_refresh_dispatcher.sv - change-to-LCD refresh handshake with holdoff and coalescing; LCD_DISPATCH_STATS_EN adds coalesced_cnt
module lcd_refresh_dispatcher
    import lcd_dispatch_pkg::*;
#(
    parameter int VALUE_W       = 3,
    parameter int HOLDOFF_COUNT = DEF_HOLDOFF_COUNT,
    parameter int TIMEOUT_COUNT = DEF_TIMEOUT_COUNT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               change,
    input  logic [VALUE_W-1:0] value,
    input  logic               refresh_done,
    input  logic               err_clr,
    output logic               refresh_req,
    output logic [VALUE_W-1:0] refresh_code,
    output logic               busy,
    output logic               timeout_err
`ifdef LCD_DISPATCH_STATS_EN
    ,
    output logic [7:0]         coalesced_cnt
`endif
);

    logic [1:0]         state_q, state_d;
    logic               change_q, change_d;
    logic               pending_q, pending_d;
    logic [VALUE_W-1:0] pend_value_q, pend_value_d;
    logic [VALUE_W-1:0] code_q, code_d;
    logic               err_q, err_d;

    logic rise;
    logic hold_tc;
    logic tmo_tc;
    logic post_handshake;
    logic decide;

    assign rise = change && !change_q;

    dispatch_timer #(.COUNT(HOLDOFF_COUNT)) u_holdoff_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != HOLDOFF),
        .enable (state_q == HOLDOFF),
        .tc     (hold_tc)
    );

    dispatch_timer #(.COUNT(TIMEOUT_COUNT)) u_timeout_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_q != REQUEST) || refresh_done),
        .enable (state_q == REQUEST),
        .tc     (tmo_tc)
    );

    always_comb begin
        state_d        = state_q;
        change_d       = change;
        pending_d      = pending_q;
        pend_value_d   = pend_value_q;
        code_d         = code_q;
        err_d          = err_q && !err_clr;
        post_handshake = 1'b0;
        decide         = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    code_d  = value;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (rise) begin
                    pending_d    = 1'b1;
                    pend_value_d = value;
                end
                if (refresh_done) begin
                    post_handshake = 1'b1;
                end else if (tmo_tc) begin
                    err_d          = 1'b1;
                    post_handshake = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_tc) begin
                    decide = 1'b1;
                end else if (rise) begin
                    pending_d    = 1'b1;
                    pend_value_d = value;
                end
            end
            default: state_d = IDLE;
        endcase

        if (post_handshake) begin
            if (HOLDOFF_COUNT == 0) begin
                decide = 1'b1;
            end else begin
                state_d = HOLDOFF;
            end
        end

        // A rise coinciding with the decision point is fresher than anything pending.
        if (decide) begin
            if (rise) begin
                code_d    = value;
                pending_d = 1'b0;
                state_d   = REQUEST;
            end else if (pending_q) begin
                code_d    = pend_value_q;
                pending_d = 1'b0;
                state_d   = REQUEST;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            change_q     <= 1'b0;
            pending_q    <= 1'b0;
            pend_value_q <= '0;
            code_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            change_q     <= change_d;
            pending_q    <= pending_d;
            pend_value_q <= pend_value_d;
            code_q       <= code_d;
            err_q        <= err_d;
        end
    end

    assign refresh_req  = (state_q == REQUEST);
    assign busy         = (state_q != IDLE);
    assign refresh_code = code_q;
    assign timeout_err  = err_q;

`ifdef LCD_DISPATCH_STATS_EN
    logic [7:0] coal_q, coal_d;
    logic       coal_hit;

    assign coal_hit = rise && pending_q &&
                      ((state_q == REQUEST) || ((state_q == HOLDOFF) && !hold_tc));

    always_comb begin
        coal_d = coal_q;
        if (err_clr) begin
            coal_d = 8'd0;
        end else if (coal_hit && (coal_q != 8'hFF)) begin
            coal_d = coal_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coal_q <= 8'd0;
        end else begin
            coal_q <= coal_d;
        end
    end

    assign coalesced_cnt = coal_q;
`endif

endmodule

// File: tb/tb_lcd_refresh_dispatcher.sv
// tb/tb_lcd_refresh_dispatcher.sv - scoreboard bench with a transaction-level reference model for lcd_refresh_dispatcher
module tb_lcd_refresh_dispatcher;

    localparam int VW = 3;
    localparam int HC = 4;
    localparam int TC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          change;
    logic [VW-1:0] value;
    logic          refresh_done;
    logic          err_clr;
    logic          refresh_req;
    logic [VW-1:0] refresh_code;
    logic          busy;
    logic          timeout_err;
`ifdef LCD_DISPATCH_STATS_EN
    logic [7:0]    coalesced_cnt;
`endif

    lcd_refresh_dispatcher #(
        .VALUE_W       (VW),
        .HOLDOFF_COUNT (HC),
        .TIMEOUT_COUNT (TC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .change        (change),
        .value         (value),
        .refresh_done  (refresh_done),
        .err_clr       (err_clr),
        .refresh_req   (refresh_req),
        .refresh_code  (refresh_code),
        .busy          (busy),
        .timeout_err   (timeout_err)
`ifdef LCD_DISPATCH_STATS_EN
        ,
        .coalesced_cnt (coalesced_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = idle, 1 = waiting for the writer, 2 = cooling down.
    int            m_phase = 0;
    int            m_age   = 0;
    logic [VW-1:0] m_code  = '0;
    logic [VW-1:0] m_pval  = '0;
    bit            m_pend  = 1'b0;
    bit            m_err   = 1'b0;
    bit            m_prev  = 1'b0;
    int            m_coal  = 0;
    logic [VW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_code = '0; m_pval = '0;
        m_pend = 0; m_err = 0; m_prev = 0; m_coal = 0;
        exp_q.delete();
    endtask

    task automatic start_req(input logic [VW-1:0] v);
        m_code  = v;
        m_phase = 1;
        m_age   = 0;
        exp_q.push_back(v);
    endtask

    task automatic note_pending(input logic [VW-1:0] v);
        if (m_pend && m_coal < 255) m_coal++;
        m_pend = 1;
        m_pval = v;
    endtask

    task automatic model_step(input bit chg, input logic [VW-1:0] val, input bit done, input bit clr);
        bit rise;
        rise   = chg && !m_prev;
        m_prev = chg;
        if (clr) m_err = 0;
        case (m_phase)
            0: if (rise) start_req(val);
            1: begin
                if (rise) note_pending(val);
                if (done) begin
                    m_phase = 2; m_age = 0;
                end else if (m_age == TC - 1) begin
                    m_err = 1; m_phase = 2; m_age = 0;
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (m_age == HC - 1) begin
                    if (rise) begin
                        m_pend = 0; start_req(val);
                    end else if (m_pend) begin
                        m_pend = 0; start_req(m_pval);
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    if (rise) note_pending(val);
                    m_age++;
                end
            end
        endcase
        if (clr) m_coal = 0;
    endtask

    task automatic cyc(input bit chg, input logic [VW-1:0] val, input bit done, input bit clr);
        @(negedge clk);
        change = chg; value = val; refresh_done = done; err_clr = clr;
        model_step(chg, val, done, clr);
    endtask

    task automatic finish_req(input int delay, input bit chg, input logic [VW-1:0] val);
        for (int i = 0; i < 200; i++) begin
            if (m_phase == 1 && m_age == delay) begin
                cyc(chg, val, 1'b1, 1'b0);
                return;
            end
            cyc(chg, val, 1'b0, 1'b0);
        end
        fail_bound("finish_req");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (m_phase == 0) return;
            cyc(1'b0, '0, (m_phase == 1 && m_age == 1), 1'b0);
        end
        fail_bound("wait_idle");
    endtask

    // Monitor: per-cycle output checks plus scoreboard pop on every new request.
    initial begin
        bit prev_req;
        prev_req = 0;
        forever begin
            @(posedge clk);
            #2;
            chk("req", refresh_req, (m_phase == 1));
            chk("busy", busy, (m_phase != 0));
            chk("timeout_err", timeout_err, m_err);
            chk("code", refresh_code, m_code);
            if (refresh_req && !prev_req) begin
                chk("req_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("req_code", refresh_code, exp_q.pop_front());
            end
            prev_req = refresh_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; change = 1'b1; value = 3'd5; refresh_done = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_req", refresh_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_code", refresh_code, 0);

        // change already high at release must still be seen as a rise
        reset = 1'b0;
        model_step(1'b1, 3'd5, 1'b0, 1'b0);
        finish_req(1, 1'b1, 3'd5);
        wait_idle();

        // single change, done three cycles after req
        cyc(0, 0, 0, 0);
        cyc(1, 3, 0, 0);
        finish_req(3, 1'b0, 3'd0);
        wait_idle();

        // level held for 20 cycles yields one request
        cyc(1, 6, 0, 0);
        finish_req(2, 1'b1, 3'd6);
        repeat (16) cyc(1, 3'($urandom), 0, 0);
        cyc(0, 0, 0, 0);
        wait_idle();

        // coalescing: 1 then 5 during REQUEST, only 5 survives
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 5, 0, 0);
        finish_req(6, 1'b0, 3'd5);
        wait_idle();
`ifdef LCD_DISPATCH_STATS_EN
        chk("coalesced_cnt", coalesced_cnt, m_coal);
`endif

        // timeout with no done, then err_clr
        cyc(1, 2, 0, 0);
        for (int i = 0; i < TC + HC + 2; i++) cyc(0, 0, 0, 0);
        chk("timeout_err_set", timeout_err, 1);
        cyc(0, 0, 0, 1);
        @(posedge clk); #2;
        chk("timeout_err_cleared", timeout_err, 0);

        // rise exactly at holdoff terminal count beats pending value 4
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 4, 0, 0);
        finish_req(4, 1'b0, 3'd4);
        for (int i = 0; i < 20 && !(m_phase == 2 && m_age == HC - 1); i++) cyc(0, 0, 0, 0);
        cyc(1, 6, 0, 0);
        @(posedge clk); #2;
        chk("boundary_code", refresh_code, 6);
        finish_req(1, 1'b1, 3'd6);
        cyc(0, 0, 0, 0);
        wait_idle();

        // done on the same cycle the timeout would fire: no error
        cyc(1, 7, 0, 0);
        finish_req(TC - 1, 1'b0, 3'd7);
        wait_idle();
        @(posedge clk); #2;
        chk("done_beats_timeout", timeout_err, 0);

        // asynchronous reset in the middle of REQUEST
        cyc(1, 3, 0, 0);
        cyc(1, 3, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1; change = 1'b0;
        model_reset();
        #1;
        chk("async_reset_req", refresh_req, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_code", refresh_code, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_step(1'b0, '0, 1'b0, 1'b0);
        repeat (6) cyc(0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit c, d, e;
            c = ($urandom_range(0, 3) == 0) ? !change : change;
            d = (m_phase == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 31) == 0);
            cyc(c, 3'($urandom), d, e);
        end
        cyc(0, 0, 0, 0);
        wait_idle();
        repeat (3) cyc(0, 0, 0, 0);
`ifdef LCD_DISPATCH_STATS_EN
        chk("coalesced_cnt_final", coalesced_cnt, m_coal);
`endif
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
